// File: rtl/gcm_block_sequencer.sv
// gcm_block_sequencer: upstream feeder for gcm_aes.
// Latches a message command, packs a 32-bit word stream into zero-padded
// 128-bit AAD/PT blocks and issues them one per strobe, together with the
// new-instance / pt-instance framing and bit-length outputs gcm_aes expects.
// Data vectors use ascending bit order so the first stream byte lands in
// bits [0:7], matching the big-endian byte layout of GCM blocks.
module gcm_block_sequencer #(
  parameter int LEN_W  = 32,
  parameter int SIZE_W = 64
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [0:127]      i_cipher_key,
  input  logic [0:95]       i_iv,
  input  logic [LEN_W-1:0]  i_aad_bytes,
  input  logic [LEN_W-1:0]  i_pt_bytes,
  input  logic              i_s_valid,
  input  logic [0:31]       i_s_data,
  output logic              o_s_ready,
  output logic              o_busy,
  output logic              o_blk_valid,
  output logic              o_new_instance,
  output logic              o_pt_instance,
  output logic [0:127]      o_aad,
  output logic [0:127]      o_plain_text,
  output logic [0:127]      o_cipher_key,
  output logic [0:95]       o_iv,
  output logic [SIZE_W-1:0] o_aad_size,
  output logic [SIZE_W-1:0] o_plain_text_size,
  output logic              o_done
);

  typedef enum logic [2:0] {
    IDLE, AAD_FILL, AAD_ISSUE, PT_FILL, PT_ISSUE, DONE
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] pt_len;
  logic [1:0]       slot;
  logic [0:127]     blk;
  logic             first_pending;
  logic             pt_first;
  logic             hold;

  logic [2:0]       word_bytes;
  logic [0:31]      masked;
  logic [0:127]     filled;
  logic [LEN_W-1:0] rem_next;
  logic             blk_done;

  // Datapath for the word being offered: trim bytes past the section end,
  // merge the word into the current slot and decide whether the block closes.
  always_comb begin
    word_bytes = (rem > LEN_W'(3)) ? 3'd4 : rem[2:0];
    masked = '0;
    for (int b = 0; b < 4; b++) begin
      masked[8*b +: 8] = (b < int'(word_bytes)) ? i_s_data[8*b +: 8] : 8'h00;
    end
    filled = blk;
    filled[{slot, 5'b00000} +: 32] = masked;
    rem_next = rem - LEN_W'(word_bytes);
    blk_done = (slot == 2'd3) || (rem_next == '0);
  end

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state             <= IDLE;
      rem               <= '0;
      pt_len            <= '0;
      slot              <= '0;
      blk               <= '0;
      first_pending     <= 1'b0;
      pt_first          <= 1'b0;
      hold              <= 1'b0;
      o_s_ready         <= 1'b0;
      o_busy            <= 1'b0;
      o_blk_valid       <= 1'b0;
      o_new_instance    <= 1'b0;
      o_pt_instance     <= 1'b0;
      o_aad             <= '0;
      o_plain_text      <= '0;
      o_cipher_key      <= '0;
      o_iv              <= '0;
      o_aad_size        <= '0;
      o_plain_text_size <= '0;
      o_done            <= 1'b0;
    end else begin
      o_blk_valid <= 1'b0;
      o_done      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            o_cipher_key      <= i_cipher_key;
            o_iv              <= i_iv;
            o_aad_size        <= SIZE_W'({i_aad_bytes, 3'b000});
            o_plain_text_size <= SIZE_W'({i_pt_bytes, 3'b000});
            pt_len            <= i_pt_bytes;
            first_pending     <= 1'b1;
            pt_first          <= 1'b1;
            slot              <= '0;
            blk               <= '0;
            o_busy            <= 1'b1;
            if (i_aad_bytes != '0) begin
              rem       <= i_aad_bytes;
              state     <= AAD_FILL;
              o_s_ready <= 1'b1;
            end else if (i_pt_bytes != '0) begin
              rem       <= i_pt_bytes;
              state     <= PT_FILL;
              o_s_ready <= 1'b1;
            end else begin
              // Empty message: one framing cycle with both flags, then done.
              state          <= DONE;
              hold           <= 1'b1;
              o_new_instance <= 1'b1;
              o_pt_instance  <= 1'b1;
            end
          end
        end
        AAD_FILL, PT_FILL: begin
          if (i_s_valid) begin
            rem <= rem_next;
            if (blk_done) begin
              slot           <= '0;
              blk            <= '0;
              o_s_ready      <= 1'b0;
              o_blk_valid    <= 1'b1;
              o_new_instance <= first_pending;
              first_pending  <= 1'b0;
              if (state == AAD_FILL) begin
                o_aad <= filled;
                state <= AAD_ISSUE;
              end else begin
                o_plain_text  <= filled;
                o_pt_instance <= pt_first;
                pt_first      <= 1'b0;
                state         <= PT_ISSUE;
              end
            end else begin
              blk  <= filled;
              slot <= slot + 2'd1;
            end
          end
        end
        AAD_ISSUE: begin
          o_aad          <= '0;
          o_new_instance <= 1'b0;
          if (rem != '0) begin
            state     <= AAD_FILL;
            o_s_ready <= 1'b1;
          end else if (pt_len != '0) begin
            rem       <= pt_len;
            state     <= PT_FILL;
            o_s_ready <= 1'b1;
          end else begin
            state  <= DONE;
            o_done <= 1'b1;
          end
        end
        PT_ISSUE: begin
          o_plain_text   <= '0;
          o_new_instance <= 1'b0;
          o_pt_instance  <= 1'b0;
          if (rem != '0) begin
            state     <= PT_FILL;
            o_s_ready <= 1'b1;
          end else begin
            state  <= DONE;
            o_done <= 1'b1;
          end
        end
        DONE: begin
          if (hold) begin
            hold           <= 1'b0;
            o_new_instance <= 1'b0;
            o_pt_instance  <= 1'b0;
            o_done         <= 1'b1;
          end else begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcm_block_sequencer.sv
// tb_gcm_block_sequencer: directed test of the GCM block sequencer using the
// GCM test case 4 vectors plus padding, empty, stall and disturbance cases.
module tb_gcm_block_sequencer;
  localparam int LEN_W  = 32;
  localparam int SIZE_W = 64;

  logic              clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_start = 1'b0;
  logic [0:127]      i_cipher_key = '0;
  logic [0:95]       i_iv = '0;
  logic [LEN_W-1:0]  i_aad_bytes = '0;
  logic [LEN_W-1:0]  i_pt_bytes = '0;
  logic              i_s_valid = 1'b0;
  logic [0:31]       i_s_data = '0;
  logic              o_s_ready, o_busy, o_blk_valid, o_new_instance, o_pt_instance, o_done;
  logic [0:127]      o_aad, o_plain_text, o_cipher_key;
  logic [0:95]       o_iv;
  logic [SIZE_W-1:0] o_aad_size, o_plain_text_size;

  localparam logic [0:127] KEY = 128'hFEFFE9928665731C6D6A8F9467308308;
  localparam logic [0:95]  IV  = 96'hCAFEBABEFACEDBADDECAF888;

  gcm_block_sequencer #(.LEN_W(LEN_W), .SIZE_W(SIZE_W)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_cipher_key(i_cipher_key), .i_iv(i_iv),
    .i_aad_bytes(i_aad_bytes), .i_pt_bytes(i_pt_bytes),
    .i_s_valid(i_s_valid), .i_s_data(i_s_data), .o_s_ready(o_s_ready),
    .o_busy(o_busy), .o_blk_valid(o_blk_valid),
    .o_new_instance(o_new_instance), .o_pt_instance(o_pt_instance),
    .o_aad(o_aad), .o_plain_text(o_plain_text),
    .o_cipher_key(o_cipher_key), .o_iv(o_iv),
    .o_aad_size(o_aad_size), .o_plain_text_size(o_plain_text_size),
    .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:127] aad;
    logic [0:127] pt;
    logic         nw;
    logic         pti;
    int           c;
  } rec_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  rec_t        caps[$];
  logic [0:31] stream[$];
  bit          done_seen = 0;
  int          done_c = 0;
  int          words_acc = 0;
  int          last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Word acceptance is sampled at the active edge, where inputs are stable.
  always @(posedge clk) begin
    if (i_s_valid && o_s_ready) begin
      words_acc++;
      last_acc = cyc + 1;
    end
  end

  // Issued blocks and done pulses are captured mid-cycle.
  always @(negedge clk) begin
    if (o_blk_valid) caps.push_back('{o_aad, o_plain_text, o_new_instance, o_pt_instance, cyc});
    if (o_done) begin
      done_seen = 1;
      done_c = cyc;
    end
  end

  task automatic start_cmd(input logic [31:0] aad, input logic [31:0] pt);
    @(negedge clk);
    caps.delete();
    done_seen = 0;
    words_acc = 0;
    i_cipher_key = KEY;
    i_iv = IV;
    i_aad_bytes = aad;
    i_pt_bytes = pt;
    i_start = 1;
    @(negedge clk);
    i_start = 0;
  endtask

  task automatic send_stream(input bit toggle, input int mid_start_at);
    logic [31:0] sa, sp;
    int waitc;
    sa = i_aad_bytes;
    sp = i_pt_bytes;
    for (int k = 0; k < stream.size(); k++) begin
      waitc = 0;
      i_s_valid = 1;
      i_s_data = stream[k];
      if (k == mid_start_at) begin
        i_start = 1;
        i_aad_bytes = 4;
        i_pt_bytes = 0;
      end
      while (!o_s_ready && waitc < 20) begin
        @(negedge clk);
        waitc++;
      end
      if (!o_s_ready) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL stream_ready word %0d: ready=0 after %0d cycles, required 1", k, waitc);
        i_s_valid = 0;
        i_start = 0;
        return;
      end
      @(negedge clk);
      i_start = 0;
      i_aad_bytes = sa;
      i_pt_bytes = sp;
      if (toggle) begin
        i_s_valid = 0;
        @(negedge clk);
      end
    end
    i_s_valid = 0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done_seen && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!done_seen) begin
      miscompares++;
      $display("[TB] FAIL done_timeout: o_done not seen within %0d cycles, required 1 pulse", n);
    end
  endtask

  task automatic load_tc4();
    stream = {32'hFEEDFACE, 32'hDEADBEEF, 32'hFEEDFACE, 32'hDEADBEEF, 32'hABADDAD2,
              32'hD9313225, 32'hF88406E5, 32'hA55909C5, 32'hAFF5269A,
              32'h86A7A953, 32'h1534F7DA, 32'h2E4C303D, 32'h8A318A72,
              32'h1C3C0C95, 32'h95680953, 32'h2FCF0E24, 32'h49A6B525,
              32'hB16AEDF5, 32'hAA0DE657, 32'hBA637B39};
  endtask

  task automatic test_reset();
    i_rst_n = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({o_s_ready, o_busy, o_blk_valid, o_new_instance, o_pt_instance, o_done} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b, required 000000",
               {o_s_ready, o_busy, o_blk_valid, o_new_instance, o_pt_instance, o_done});
    end
    vectors++;
    if ({o_aad, o_plain_text, o_cipher_key, o_iv} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: aad=%h pt=%h key=%h iv=%h, required all 0",
               o_aad, o_plain_text, o_cipher_key, o_iv);
    end
    vectors++;
    if ({o_aad_size, o_plain_text_size} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_sizes: aad_size=%0d pt_size=%0d, required 0 0", o_aad_size, o_plain_text_size);
    end
    i_rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_tc4(input int mid_start_at);
    start_cmd(20, 60);
    send_stream(0, mid_start_at);
    wait_done();
    vectors++;
    if (caps.size() != 6) begin
      miscompares++;
      $display("[TB] FAIL tc4_block_count: got %0d blocks, required 6", caps.size());
      return;
    end
    vectors++;
    if (caps[0].aad !== 128'hFEEDFACEDEADBEEFFEEDFACEDEADBEEF || {caps[0].nw, caps[0].pti} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL tc4_aad0: got %h flags %b%b, required feedfacedeadbeeffeedfacedeadbeef flags 10",
               caps[0].aad, caps[0].nw, caps[0].pti);
    end
    vectors++;
    if (caps[1].aad !== 128'hABADDAD2000000000000000000000000 || {caps[1].nw, caps[1].pti} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL tc4_aad1: got %h flags %b%b, required abaddad2000000000000000000000000 flags 00",
               caps[1].aad, caps[1].nw, caps[1].pti);
    end
    vectors++;
    if (caps[1].pt !== '0 || caps[2].aad !== '0) begin
      miscompares++;
      $display("[TB] FAIL tc4_other_zero: pt during aad=%h aad during pt=%h, required 0 0", caps[1].pt, caps[2].aad);
    end
    vectors++;
    if (caps[2].pt !== 128'hD9313225F88406E5A55909C5AFF5269A || {caps[2].nw, caps[2].pti} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL tc4_pt0: got %h flags %b%b, required d9313225f88406e5a55909c5aff5269a flags 01",
               caps[2].pt, caps[2].nw, caps[2].pti);
    end
    vectors++;
    if (caps[3].pt !== 128'h86A7A9531534F7DA2E4C303D8A318A72 || caps[4].pt !== 128'h1C3C0C95956809532FCF0E2449A6B525) begin
      miscompares++;
      $display("[TB] FAIL tc4_pt12: got %h %h, required 86a7a9531534f7da2e4c303d8a318a72 1c3c0c95956809532fcf0e2449a6b525",
               caps[3].pt, caps[4].pt);
    end
    vectors++;
    if (caps[5].pt !== 128'hB16AEDF5AA0DE657BA637B3900000000 || {caps[5].nw, caps[5].pti} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL tc4_pt3: got %h flags %b%b, required b16aedf5aa0de657ba637b3900000000 flags 00",
               caps[5].pt, caps[5].nw, caps[5].pti);
    end
    vectors++;
    if (caps[3].c - caps[2].c != 5) begin
      miscompares++;
      $display("[TB] FAIL tc4_throughput: block spacing %0d cycles, required 5", caps[3].c - caps[2].c);
    end
    vectors++;
    if (done_c != caps[5].c + 1) begin
      miscompares++;
      $display("[TB] FAIL tc4_done_latency: done at %0d, required %0d", done_c, caps[5].c + 1);
    end
    vectors++;
    if (o_aad_size !== 64'd160 || o_plain_text_size !== 64'd480) begin
      miscompares++;
      $display("[TB] FAIL tc4_sizes: got %0d %0d, required 160 480", o_aad_size, o_plain_text_size);
    end
    vectors++;
    if (o_cipher_key !== KEY || o_iv !== IV) begin
      miscompares++;
      $display("[TB] FAIL tc4_key_iv: got %h %h, required %h %h", o_cipher_key, o_iv, KEY, IV);
    end
    vectors++;
    if (words_acc != 20) begin
      miscompares++;
      $display("[TB] FAIL tc4_words: accepted %0d, required 20", words_acc);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL tc4_idle_after: busy=%b done=%b, required 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_garbage_pad();
    stream = {32'hFEEDFACE, 32'hDEADBEEF, 32'hFEEDFACE, 32'hDEADBEEF, 32'hABADFFFF,
              32'hD9313225, 32'hF88406E5, 32'hA55909C5, 32'hAFFFFFFF};
    start_cmd(18, 13);
    send_stream(0, -1);
    wait_done();
    vectors++;
    if (caps.size() != 3) begin
      miscompares++;
      $display("[TB] FAIL pad_block_count: got %0d blocks, required 3", caps.size());
      return;
    end
    vectors++;
    if (caps[1].aad !== 128'hABAD0000000000000000000000000000) begin
      miscompares++;
      $display("[TB] FAIL pad_aad: got %h, required abad0000000000000000000000000000", caps[1].aad);
    end
    vectors++;
    if (caps[2].pt !== 128'hD9313225F88406E5A55909C5AF000000 || {caps[2].nw, caps[2].pti} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL pad_pt: got %h flags %b%b, required d9313225f88406e5a55909c5af000000 flags 01",
               caps[2].pt, caps[2].nw, caps[2].pti);
    end
    vectors++;
    if (o_aad_size !== 64'd144 || o_plain_text_size !== 64'd104 || words_acc != 9) begin
      miscompares++;
      $display("[TB] FAIL pad_sizes: sizes %0d %0d words %0d, required 144 104 9",
               o_aad_size, o_plain_text_size, words_acc);
    end
  endtask

  task automatic test_empty();
    @(negedge clk);
    caps.delete();
    words_acc = 0;
    i_aad_bytes = 0;
    i_pt_bytes = 0;
    i_s_valid = 1;
    i_s_data = 32'h12345678;
    i_start = 1;
    @(negedge clk);
    i_start = 0;
    vectors++;
    if ({o_new_instance, o_pt_instance, o_blk_valid, o_done} !== 4'b1100) begin
      miscompares++;
      $display("[TB] FAIL empty_flags: got %b, required 1100",
               {o_new_instance, o_pt_instance, o_blk_valid, o_done});
    end
    @(negedge clk);
    vectors++;
    if ({o_new_instance, o_pt_instance, o_blk_valid, o_done} !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL empty_done: got %b, required 0001",
               {o_new_instance, o_pt_instance, o_blk_valid, o_done});
    end
    @(negedge clk);
    vectors++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || words_acc != 0 || o_aad_size !== '0) begin
      miscompares++;
      $display("[TB] FAIL empty_after: busy=%b done=%b words=%0d aad_size=%0d, required 0 0 0 0",
               o_busy, o_done, words_acc, o_aad_size);
    end
    i_s_valid = 0;
  endtask

  task automatic test_single_pt(input bit toggle);
    stream = {32'hD9313225, 32'hF88406E5, 32'hA55909C5, 32'hAFF5269A};
    start_cmd(0, 16);
    send_stream(toggle, -1);
    wait_done();
    vectors++;
    if (caps.size() != 1) begin
      miscompares++;
      $display("[TB] FAIL single_count toggle=%0d: got %0d blocks, required 1", toggle, caps.size());
      return;
    end
    vectors++;
    if (caps[0].pt !== 128'hD9313225F88406E5A55909C5AFF5269A || {caps[0].nw, caps[0].pti} !== 2'b11 || caps[0].aad !== '0) begin
      miscompares++;
      $display("[TB] FAIL single_block toggle=%0d: got %h flags %b%b aad %h, required d9313225f88406e5a55909c5aff5269a flags 11 aad 0",
               toggle, caps[0].pt, caps[0].nw, caps[0].pti, caps[0].aad);
    end
    vectors++;
    if (caps[0].c != last_acc || done_c != caps[0].c + 1) begin
      miscompares++;
      $display("[TB] FAIL single_timing toggle=%0d: strobe %0d done %0d, required %0d %0d",
               toggle, caps[0].c, done_c, last_acc, last_acc + 1);
    end
  endtask

  task automatic test_disturb();
    load_tc4();
    stream = stream[0:1];
    start_cmd(20, 60);
    send_stream(0, -1);
    @(negedge clk);
    i_rst_n = 0;
    #1;
    vectors++;
    if ({o_s_ready, o_busy, o_blk_valid, o_new_instance, o_pt_instance, o_done} !== 6'b0 ||
        o_cipher_key !== '0 || o_aad_size !== '0 || o_plain_text_size !== '0) begin
      miscompares++;
      $display("[TB] FAIL disturb_reset: flags %b key %h sizes %0d %0d, required all 0",
               {o_s_ready, o_busy, o_blk_valid, o_new_instance, o_pt_instance, o_done},
               o_cipher_key, o_aad_size, o_plain_text_size);
    end
    @(negedge clk);
    i_rst_n = 1;
    repeat (3) @(negedge clk);
    vectors++;
    if (caps.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL disturb_no_block: got %0d blocks, required 0", caps.size());
    end
    load_tc4();
    test_tc4(2);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    load_tc4();
    test_tc4(-1);
    test_garbage_pad();
    test_empty();
    test_single_pt(0);
    test_single_pt(1);
    test_disturb();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gcm_block_sequencer.md
Name: gcm_block_sequencer

Overview:
- Upstream feeder for gcm_aes. Accepts a message command (key, IV, AAD and PT byte lengths) and a 32-bit word stream with valid/ready.
- Packs the stream into 128-bit blocks, zero-pads the final partial block of each section and issues blocks one per strobe.
- Generates gcm_aes's i_new_instance / i_pt_instance framing and its bit-length inputs.

Parameters:
- LEN_W, 32, width of byte-length command fields
- SIZE_W, 64, width of bit-length outputs (must be >= LEN_W+3)

Ports:
- clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle pulse, latches command
- i_cipher_key  in  128  key, latched on accepted i_start
- i_iv  in  96  IV, latched on accepted i_start
- i_aad_bytes  in  LEN_W  AAD length in bytes
- i_pt_bytes  in  LEN_W  PT length in bytes
- i_s_valid  in  1  stream word valid
- i_s_data  in  32  stream word; first byte in bits [0:7]
- o_s_ready  out  1  stream word accepted when valid&ready
- o_busy  out  1  command in progress
- o_blk_valid  out  1  one-cycle block strobe
- o_new_instance  out  1  first block of message
- o_pt_instance  out  1  first PT block
- o_aad  out  128  AAD block (valid with o_blk_valid in AAD phase)
- o_plain_text  out  128  PT block (valid with o_blk_valid in PT phase)
- o_cipher_key  out  128  latched key
- o_iv  out  96  latched IV
- o_aad_size  out  SIZE_W  i_aad_bytes*8, zero-extended
- o_plain_text_size  out  SIZE_W  i_pt_bytes*8, zero-extended
- o_done  out  1  one-cycle pulse after last block issued

Behaviour:
- Reset (async assert, sync deassert into IDLE): every output 0, all counters cleared. Reset mid-message drops it; no partial block is issued.
- States: IDLE, AAD_FILL, AAD_ISSUE, PT_FILL, PT_ISSUE, DONE.
- IDLE: o_s_ready=0, o_busy=0. i_start latches key, IV, lengths and size outputs.
  - aad>0 -> AAD_FILL.
  - aad=0, pt>0 -> PT_FILL.
  - both 0 -> DONE, with one cycle of o_new_instance=1, o_pt_instance=1, o_blk_valid=0.
- i_start while o_busy=1 is ignored.
- FILL states: o_s_ready=1. Each accepted word shifts into the block register at word slot 0..3 (slot 0 = bits [0:31]). A remaining-byte counter decrements by min(4, remaining).
- A block completes on the 4th word or on the word that exhausts the section.
  - Bytes beyond the section length are forced to 0 (whole unfilled slots and the unused bytes of the last word), regardless of i_s_data.
  - Next state is the matching ISSUE state.
- ISSUE states: o_s_ready=0, o_blk_valid=1 for exactly one cycle, block on o_aad or o_plain_text; the other block output holds 0.
  - o_new_instance=1 only on the first issued block of the message.
  - o_pt_instance=1 only on the first PT block.
  - If aad=0, the first PT block carries both flags.
- ISSUE exit:
  - Bytes remain in section -> FILL of the same section.
  - AAD exhausted, pt>0 -> PT_FILL.
  - Otherwise -> DONE.
- Each section starts word-aligned: PT never shares a stream word with AAD.
- DONE: o_done=1 for one cycle -> IDLE.
- o_cipher_key, o_iv, o_aad_size and o_plain_text_size hold their latched values until the next accepted i_start.
- Latency: o_blk_valid is asserted the cycle after the block-completing word is accepted. Throughput is 1 block per 5 cycles with a continuous stream.
- Stalls: i_s_valid low in FILL leaves state and counters unchanged.
- Block count per section = ceil(bytes/16); lengths up to 2^LEN_W-1 are supported.

Test Plan:
- Test case 4 vectors:
  - key FEFFE9928665731C6D6A8F9467308308, IV CAFEBABEFACEDBADDECAF888.
  - aad=20: FEEDFACEDEADBEEFFEEDFACEDEADBEEFABADDAD2.
  - pt=60: D9313225...B16AEDF5AA0DE657BA637B39.
- Test case 4 AAD side:
  - 2 AAD blocks; first block carries o_new_instance.
  - Second block ABADDAD2000000000000000000000000.
  - o_aad_size=160.
- Test case 4 PT side:
  - 4 PT blocks; first block carries o_pt_instance.
  - Last block B16AEDF5AA0DE657BA637B3900000000.
  - o_plain_text_size=480; o_done 1 cycle after the 4th PT strobe.
- Garbage padding bytes: same stimulus with last-word pad bytes FF -> identical padded blocks (zeros).
- Empty message: aad=0, pt=0 -> one cycle with new=pt=1 and blk_valid=0, o_done next cycle, zero words consumed.
- aad=0, pt=16 -> single block with o_new_instance=1, o_pt_instance=1 and o_blk_valid=1. With i_s_valid toggled 1/0 every cycle -> same block, issued the cycle after the 4th accept.
- Disturbances:
  - i_rst_n low after 2 AAD words -> all outputs 0 immediately.
  - A following i_start runs cleanly.
  - i_start pulsed mid-message is ignored (lengths unchanged).
